// File: rtl/mips_pipeline_if.sv
// Debug/control bus between the debug unit (master) and the pipeline core (slave).
interface mips_pipeline_if #(
  parameter int unsigned NB = 32
);
  logic          i_step;
  logic [4:0]    i_debug_mips_register_number;
  logic [NB-1:0] i_debug_address;
  logic [NB-1:0] o_mips_pc;
  logic [NB-1:0] o_mips_alu_result;
  logic [NB-1:0] o_mips_register_data;
  logic [NB-1:0] o_mips_data_memory;

  modport master (
    output i_step, i_debug_mips_register_number, i_debug_address,
    input  o_mips_pc, o_mips_alu_result, o_mips_register_data, o_mips_data_memory
  );

  modport slave (
    input  i_step, i_debug_mips_register_number, i_debug_address,
    output o_mips_pc, o_mips_alu_result, o_mips_register_data, o_mips_data_memory
  );
endinterface

// File: rtl/mips_pipeline.sv
// Five-stage 32-bit MIPS integer pipeline (no forwarding/stalls) with on-chip instruction and
// data memories; advanced one stage per stepped clock and observable through the debug bus.
module mips_pipeline #(
  parameter int unsigned NB              = 32,
  parameter int unsigned NB_SIZE_TYPE    = 3,
  parameter int unsigned TAM_DATA_MEMORY = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mips_pipeline_if.slave dbg
);
  localparam int unsigned DmemAw    = $clog2(TAM_DATA_MEMORY);
  localparam int unsigned ImemDepth = 16;
  localparam int unsigned ImemAw    = 4;

  localparam logic [NB_SIZE_TYPE-1:0] SzByte = NB_SIZE_TYPE'(1);
  localparam logic [NB_SIZE_TYPE-1:0] SzHalf = NB_SIZE_TYPE'(2);
  localparam logic [NB_SIZE_TYPE-1:0] SzWord = NB_SIZE_TYPE'(4);

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  typedef struct packed {
    alu_op_e                 alu_op;
    logic [NB-1:0]           op_a;
    logic [NB-1:0]           op_b;
    logic [4:0]              shamt;
    logic [NB-1:0]           store_data;
    logic [4:0]              dest;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic [NB_SIZE_TYPE-1:0] size;
    logic                    is_unsigned;
  } id_ex_t;

  typedef struct packed {
    logic [NB-1:0]           alu_result;
    logic [NB-1:0]           store_data;
    logic [4:0]              dest;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic [NB_SIZE_TYPE-1:0] size;
    logic                    is_unsigned;
  } ex_mem_t;

  typedef struct packed {
    logic [NB-1:0] wdata;
    logic [4:0]    dest;
    logic          reg_write;
  } mem_wb_t;

  // Loaded externally (hierarchically) by whoever owns the program image.
  logic [NB-1:0] imem [ImemDepth];

  logic [NB-1:0] pc_q, if_id_q;
  id_ex_t        id_ex_d, id_ex_q;
  ex_mem_t       ex_mem_d, ex_mem_q;
  mem_wb_t       mem_wb_d, mem_wb_q;
  logic [NB-1:0] gpr_q [32];
  logic [NB-1:0] dmem_q [TAM_DATA_MEMORY];

  // ---------------- ID ----------------
  logic [5:0]              opcode, funct;
  logic [4:0]              rs, rt, rd, shamt;
  logic [NB-1:0]           rs_val, rt_val, imm_sext, imm_zext;
  logic [NB_SIZE_TYPE-1:0] size_code;

  assign opcode   = if_id_q[31:26];
  assign rs       = if_id_q[25:21];
  assign rt       = if_id_q[20:16];
  assign rd       = if_id_q[15:11];
  assign shamt    = if_id_q[10:6];
  assign funct    = if_id_q[5:0];
  assign rs_val   = gpr_q[rs];
  assign rt_val   = gpr_q[rt];
  assign imm_sext = {{(NB-16){if_id_q[15]}}, if_id_q[15:0]};
  assign imm_zext = {{(NB-16){1'b0}}, if_id_q[15:0]};
  // Loads and stores share the byte/half/word encoding in opcode[1:0].
  assign size_code = (opcode[1:0] == 2'b00) ? SzByte :
                     (opcode[1:0] == 2'b01) ? SzHalf : SzWord;

  always_comb begin
    id_ex_d            = '0;
    id_ex_d.op_a       = rs_val;
    id_ex_d.op_b       = rt_val;
    id_ex_d.shamt      = shamt;
    id_ex_d.store_data = rt_val;
    id_ex_d.dest       = rt;
    case (opcode)
      6'h00: begin
        id_ex_d.dest      = rd;
        id_ex_d.reg_write = 1'b1;
        case (funct)
          6'h00:   id_ex_d.alu_op = AluSll;
          6'h02:   id_ex_d.alu_op = AluSrl;
          6'h03:   id_ex_d.alu_op = AluSra;
          6'h21:   id_ex_d.alu_op = AluAdd;
          6'h23:   id_ex_d.alu_op = AluSub;
          6'h24:   id_ex_d.alu_op = AluAnd;
          6'h25:   id_ex_d.alu_op = AluOr;
          6'h26:   id_ex_d.alu_op = AluXor;
          6'h27:   id_ex_d.alu_op = AluNor;
          6'h2a:   id_ex_d.alu_op = AluSlt;
          default: id_ex_d.reg_write = 1'b0;
        endcase
      end
      6'h09: begin
        id_ex_d.alu_op = AluAdd; id_ex_d.op_b = imm_sext; id_ex_d.reg_write = 1'b1;
      end
      6'h0a: begin
        id_ex_d.alu_op = AluSlt; id_ex_d.op_b = imm_sext; id_ex_d.reg_write = 1'b1;
      end
      6'h0c: begin
        id_ex_d.alu_op = AluAnd; id_ex_d.op_b = imm_zext; id_ex_d.reg_write = 1'b1;
      end
      6'h0d: begin
        id_ex_d.alu_op = AluOr; id_ex_d.op_b = imm_zext; id_ex_d.reg_write = 1'b1;
      end
      6'h0e: begin
        id_ex_d.alu_op = AluXor; id_ex_d.op_b = imm_zext; id_ex_d.reg_write = 1'b1;
      end
      6'h0f: begin
        id_ex_d.alu_op = AluLui; id_ex_d.op_b = imm_zext; id_ex_d.reg_write = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
        id_ex_d.alu_op      = AluAdd;
        id_ex_d.op_b        = imm_sext;
        id_ex_d.reg_write   = 1'b1;
        id_ex_d.mem_read    = 1'b1;
        id_ex_d.size        = size_code;
        id_ex_d.is_unsigned = opcode[2];
      end
      6'h28, 6'h29, 6'h2b: begin
        id_ex_d.alu_op    = AluAdd;
        id_ex_d.op_b      = imm_sext;
        id_ex_d.mem_write = 1'b1;
        id_ex_d.size      = size_code;
      end
      default: ;
    endcase
    // Anything with no architectural effect becomes a clean bubble.
    if (!id_ex_d.reg_write && !id_ex_d.mem_write) id_ex_d = '0;
  end

  // ---------------- EX ----------------
  logic [NB-1:0] alu_result;

  always_comb begin
    alu_result = '0;
    case (id_ex_q.alu_op)
      AluAdd:  alu_result = id_ex_q.op_a + id_ex_q.op_b;
      AluSub:  alu_result = id_ex_q.op_a - id_ex_q.op_b;
      AluAnd:  alu_result = id_ex_q.op_a & id_ex_q.op_b;
      AluOr:   alu_result = id_ex_q.op_a | id_ex_q.op_b;
      AluXor:  alu_result = id_ex_q.op_a ^ id_ex_q.op_b;
      AluNor:  alu_result = ~(id_ex_q.op_a | id_ex_q.op_b);
      AluSlt:  alu_result = NB'($signed(id_ex_q.op_a) < $signed(id_ex_q.op_b));
      AluSll:  alu_result = id_ex_q.op_b << id_ex_q.shamt;
      AluSrl:  alu_result = id_ex_q.op_b >> id_ex_q.shamt;
      AluSra:  alu_result = $unsigned($signed(id_ex_q.op_b) >>> id_ex_q.shamt);
      AluLui:  alu_result = id_ex_q.op_b << 16;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    ex_mem_d             = '0;
    ex_mem_d.alu_result  = alu_result;
    ex_mem_d.store_data  = id_ex_q.store_data;
    ex_mem_d.dest        = id_ex_q.dest;
    ex_mem_d.reg_write   = id_ex_q.reg_write;
    ex_mem_d.mem_read    = id_ex_q.mem_read;
    ex_mem_d.mem_write   = id_ex_q.mem_write;
    ex_mem_d.size        = id_ex_q.size;
    ex_mem_d.is_unsigned = id_ex_q.is_unsigned;
  end

  // ---------------- MEM ----------------
  logic [DmemAw-1:0] dmem_idx;
  logic [NB-1:0]     mem_word, load_data, store_merged;
  logic [1:0]        byte_off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign dmem_idx = ex_mem_q.alu_result[DmemAw+1:2];
  assign byte_off = ex_mem_q.alu_result[1:0];
  assign mem_word = dmem_q[dmem_idx];
  assign byte_sel = 8'(mem_word >> {byte_off, 3'b000});
  assign half_sel = 16'(mem_word >> {byte_off[1], 4'b0000});

  always_comb begin
    load_data    = mem_word;
    store_merged = mem_word;
    case (ex_mem_q.size)
      SzByte: begin
        load_data = ex_mem_q.is_unsigned ? {{(NB-8){1'b0}}, byte_sel}
                                         : {{(NB-8){byte_sel[7]}}, byte_sel};
        store_merged[8*byte_off +: 8] = ex_mem_q.store_data[7:0];
      end
      SzHalf: begin
        load_data = ex_mem_q.is_unsigned ? {{(NB-16){1'b0}}, half_sel}
                                         : {{(NB-16){half_sel[15]}}, half_sel};
        store_merged[16*byte_off[1] +: 16] = ex_mem_q.store_data[15:0];
      end
      default: store_merged = ex_mem_q.store_data;
    endcase
  end

  always_comb begin
    mem_wb_d.wdata     = ex_mem_q.mem_read ? load_data : ex_mem_q.alu_result;
    mem_wb_d.dest      = ex_mem_q.dest;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
  end

  // ---------------- State ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else if (dbg.i_step) begin
      pc_q     <= pc_q + NB'(4);
      if_id_q  <= imem[pc_q[ImemAw+1:2]];
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < int'(TAM_DATA_MEMORY); k++) dmem_q[k] <= NB'(k);
    end else if (dbg.i_step && ex_mem_q.mem_write) begin
      dmem_q[dmem_idx] <= store_merged;
    end
  end

  // Falling-edge write lets an ID-stage read three instructions later see the result.
  // Rewriting the held MEM/WB value while not stepping is idempotent.
  always_ff @(negedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= NB'(i);
    end else if (mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0)) begin
      gpr_q[mem_wb_q.dest] <= mem_wb_q.wdata;
    end
  end

  // ---------------- Debug observation ----------------
  logic unused_dbg_addr;
  assign unused_dbg_addr = ^dbg.i_debug_address[NB-1:DmemAw];

  assign dbg.o_mips_pc          = pc_q;
  assign dbg.o_mips_alu_result  = alu_result;
  assign dbg.o_mips_data_memory = dmem_q[dbg.i_debug_address[DmemAw-1:0]];

  always_comb begin
    if (mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0) &&
        (mem_wb_q.dest == dbg.i_debug_mips_register_number)) begin
      dbg.o_mips_register_data = mem_wb_q.wdata;
    end else begin
      dbg.o_mips_register_data = gpr_q[dbg.i_debug_mips_register_number];
    end
  end
endmodule

// File: tb/tb_mips_pipeline.sv
// Directed test of mips_pipeline: reset state, load/store lanes, ALU ops, step hold, async reset.
module tb_mips_pipeline;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_pipeline_if #(.NB(32)) dbg ();

  mips_pipeline #(
    .NB(32),
    .NB_SIZE_TYPE(3),
    .TAM_DATA_MEMORY(16)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .dbg(dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    dbg.i_step = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    dbg.i_debug_mips_register_number = 5'd7;
    dbg.i_debug_address = 32'd2;
    #1;
    checks++;
    if (dbg.o_mips_pc !== 32'd0) begin
      errors++; $display("FAIL reset_pc: got %h want %h", dbg.o_mips_pc, 32'd0);
    end
    checks++;
    if (dbg.o_mips_alu_result !== 32'd0) begin
      errors++; $display("FAIL reset_alu: got %h want %h", dbg.o_mips_alu_result, 32'd0);
    end
    checks++;
    if (dbg.o_mips_register_data !== 32'd7) begin
      errors++; $display("FAIL reset_gpr7: got %h want %h", dbg.o_mips_register_data, 32'd7);
    end
    checks++;
    if (dbg.o_mips_data_memory !== 32'd2) begin
      errors++; $display("FAIL reset_dmem2: got %h want %h", dbg.o_mips_data_memory, 32'd2);
    end
    dbg.i_debug_mips_register_number = 5'd0;
    #1;
    checks++;
    if (dbg.o_mips_register_data !== 32'd0) begin
      errors++; $display("FAIL reset_gpr0: got %h want %h", dbg.o_mips_register_data, 32'd0);
    end
    dbg.i_step = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (dbg.o_mips_pc !== 32'(4 * t)) begin
        errors++; $display("FAIL nop_pc: got %h want %h", dbg.o_mips_pc, 32'(4 * t));
      end
    end
  endtask

  task automatic test_lb_latency();
    do_reset();
    dut.imem[1] = enc_i(6'h20, 1, 7, 16'd7);
    dbg.i_debug_mips_register_number = 5'd7;
    dbg.i_step = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (dbg.o_mips_alu_result !== 32'd8) begin
      errors++; $display("FAIL lb_ex_addr: got %h want %h", dbg.o_mips_alu_result, 32'd8);
    end
    tick();
    checks++;
    if (dbg.o_mips_register_data !== 32'd7) begin
      errors++; $display("FAIL lb_before_wb: got %h want %h", dbg.o_mips_register_data, 32'd7);
    end
    tick();
    checks++;
    if (dbg.o_mips_pc !== 32'd20) begin
      errors++; $display("FAIL lb_pc20: got %h want %h", dbg.o_mips_pc, 32'd20);
    end
    checks++;
    if (dbg.o_mips_register_data !== 32'd2) begin
      errors++; $display("FAIL lb_wb_bypass: got %h want %h", dbg.o_mips_register_data, 32'd2);
    end
    tick();
    checks++;
    if (dbg.o_mips_register_data !== 32'd2) begin
      errors++; $display("FAIL lb_written: got %h want %h", dbg.o_mips_register_data, 32'd2);
    end
  endtask

  task automatic test_loads();
    int          regs [9];
    logic [31:0] vals [9];
    regs = '{8, 9, 10, 11, 12, 13, 14, 15, 16};
    vals = '{32'h8081_F2F3, 32'hFFFF_FFF3, 32'h0000_00F3, 32'hFFFF_F2F3, 32'h0000_F2F3,
             32'h8081_F2F3, 32'h8081_F2F3, 32'hFFFF_FF80, 32'h0000_0081};
    do_reset();
    dut.imem[0]  = enc_i(6'h0f, 0, 8, 16'h8081);   // LUI  $8
    dut.imem[3]  = enc_i(6'h0d, 8, 8, 16'hF2F3);   // ORI  $8,$8
    dut.imem[6]  = enc_i(6'h2b, 4, 8, 16'd0);      // SW   $8,0($4)
    dut.imem[7]  = enc_i(6'h20, 4, 9, 16'd0);      // LB
    dut.imem[8]  = enc_i(6'h24, 4, 10, 16'd0);     // LBU
    dut.imem[9]  = enc_i(6'h21, 4, 11, 16'd1);     // LH, misaligned
    dut.imem[10] = enc_i(6'h25, 4, 12, 16'd0);     // LHU
    dut.imem[11] = enc_i(6'h23, 4, 13, 16'd3);     // LW, misaligned
    dut.imem[12] = enc_i(6'h27, 4, 14, 16'd0);     // LWU
    dut.imem[13] = enc_i(6'h20, 0, 15, 16'd7);     // LB top byte
    dut.imem[14] = enc_i(6'h24, 0, 16, 16'd6);     // LBU byte 2
    dbg.i_step = 1'b1;
    repeat (19) tick();
    checks++;
    if (dbg.o_mips_pc !== 32'd76) begin
      errors++; $display("FAIL loads_pc: got %h want %h", dbg.o_mips_pc, 32'd76);
    end
    for (int i = 0; i < 9; i++) begin
      dbg.i_debug_mips_register_number = 5'(regs[i]);
      #1;
      checks++;
      if (dbg.o_mips_register_data !== vals[i]) begin
        errors++;
        $display("FAIL load_gpr%0d: got %h want %h", regs[i], dbg.o_mips_register_data, vals[i]);
      end
    end
    dbg.i_debug_address = 32'd1;
    #1;
    checks++;
    if (dbg.o_mips_data_memory !== 32'h8081_F2F3) begin
      errors++; $display("FAIL sw_word1: got %h want %h", dbg.o_mips_data_memory, 32'h8081_F2F3);
    end
  endtask

  task automatic test_stores();
    logic [31:0] vals [3];
    vals = '{32'h0000_0200, 32'h0003_0001, 32'h0000_0002};
    do_reset();
    dut.imem[0] = enc_i(6'h28, 0, 2, 16'd1);   // SB $2,1($0)
    dut.imem[1] = enc_i(6'h29, 0, 3, 16'd6);   // SH $3,6($0)
    dbg.i_step = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      dbg.i_debug_address = 32'(k);
      #1;
      checks++;
      if (dbg.o_mips_data_memory !== vals[k]) begin
        errors++; $display("FAIL store_word%0d: got %h want %h", k, dbg.o_mips_data_memory, vals[k]);
      end
    end
  endtask

  task automatic load_arith();
    dut.imem[0]  = enc_i(6'h09, 0, 5, 16'hFFFF);   // ADDIU $5,$0,-1
    dut.imem[1]  = enc_i(6'h09, 0, 0, 16'd5);      // ADDIU $0,$0,5
    dut.imem[4]  = enc_r(5, 1, 6, 0, 6'h2a);       // SLT  $6,$5,$1
    dut.imem[5]  = enc_r(1, 5, 17, 0, 6'h23);      // SUBU $17,$1,$5
    dut.imem[6]  = enc_r(0, 5, 19, 4, 6'h00);      // SLL  $19,$5,4
    dut.imem[7]  = enc_r(0, 5, 20, 28, 6'h02);     // SRL  $20,$5,28
    dut.imem[8]  = enc_r(2, 3, 21, 0, 6'h27);      // NOR  $21,$2,$3
    dut.imem[9]  = enc_i(6'h0e, 5, 22, 16'h00FF);  // XORI $22,$5,0xFF
    dut.imem[10] = enc_i(6'h2b, 0, 5, 16'd12);     // SW   $5,12($0)
  endtask

  task automatic test_arith();
    logic [31:0] alu_exp [12];
    int          regs [8];
    logic [31:0] vals [8];
    alu_exp = '{32'h0, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'h0, 32'h1, 32'h2, 32'hFFFF_FFF0,
                32'hF, 32'hFFFF_FFFC, 32'hFFFF_FF00, 32'hC};
    regs = '{0, 5, 6, 17, 19, 20, 21, 22};
    vals = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'hF, 32'hFFFF_FFFC,
             32'hFFFF_FF00};
    do_reset();
    load_arith();
    dbg.i_step = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++;
      if (dbg.o_mips_alu_result !== alu_exp[t]) begin
        errors++;
        $display("FAIL arith_alu_pc%0d: got %h want %h", 4 * (t + 1), dbg.o_mips_alu_result,
                 alu_exp[t]);
      end
    end
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      dbg.i_debug_mips_register_number = 5'(regs[i]);
      #1;
      checks++;
      if (dbg.o_mips_register_data !== vals[i]) begin
        errors++;
        $display("FAIL arith_gpr%0d: got %h want %h", regs[i], dbg.o_mips_register_data, vals[i]);
      end
    end
    dbg.i_debug_address = 32'd3;
    #1;
    checks++;
    if (dbg.o_mips_data_memory !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL arith_sw: got %h want %h", dbg.o_mips_data_memory, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    load_arith();
    dbg.i_debug_mips_register_number = 5'd5;
    dbg.i_debug_address = 32'd3;
    dbg.i_step = 1'b1;
    repeat (6) tick();
    dbg.i_step = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (dbg.o_mips_pc !== 32'd24 || dbg.o_mips_alu_result !== 32'd1 ||
          dbg.o_mips_register_data !== 32'hFFFF_FFFF || dbg.o_mips_data_memory !== 32'd3) begin
        errors++;
        $display("FAIL hold: got pc=%h alu=%h r5=%h m3=%h want pc=18 alu=1 r5=ffffffff m3=3",
                 dbg.o_mips_pc, dbg.o_mips_alu_result, dbg.o_mips_register_data,
                 dbg.o_mips_data_memory);
      end
    end
    dbg.i_step = 1'b1;
    tick();
    checks++;
    if (dbg.o_mips_pc !== 32'd28 || dbg.o_mips_alu_result !== 32'd2) begin
      errors++;
      $display("FAIL resume: got pc=%h alu=%h want pc=1c alu=2", dbg.o_mips_pc,
               dbg.o_mips_alu_result);
    end
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dbg.o_mips_pc !== 32'd0 || dbg.o_mips_alu_result !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_pc: got pc=%h alu=%h want 0 0", dbg.o_mips_pc,
               dbg.o_mips_alu_result);
    end
    checks++;
    if (dbg.o_mips_register_data !== 32'd5) begin
      errors++; $display("FAIL async_reset_gpr5: got %h want %h", dbg.o_mips_register_data, 32'd5);
    end
    checks++;
    if (dbg.o_mips_data_memory !== 32'd3) begin
      errors++; $display("FAIL async_reset_dmem3: got %h want %h", dbg.o_mips_data_memory, 32'd3);
    end
    dbg.i_debug_mips_register_number = 5'd6;
    #1;
    checks++;
    if (dbg.o_mips_register_data !== 32'd6) begin
      errors++; $display("FAIL async_reset_gpr6: got %h want %h", dbg.o_mips_register_data, 32'd6);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    dbg.i_step = 1'b0;
    dbg.i_debug_mips_register_number = 5'd0;
    dbg.i_debug_address = 32'd0;
    test_reset();
    test_lb_latency();
    test_loads();
    test_stores();
    test_arith();
    test_hold_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
